// File: rtl/trivium_ks_xor_if.sv
// Plaintext-in / ciphertext-out handshake bundle for trivium_ks_xor.
//   pt_data, pt_valid -> producer to block; pt_ready <- block
//   ct_data, ct_valid <- block;             ct_ready -> consumer to block
// slave is the block's view, master is the surrounding system's view.
interface trivium_ks_xor_if #(
  parameter int W = 8
);
  logic [W-1:0] pt_data;
  logic         pt_valid;
  logic         pt_ready;
  logic [W-1:0] ct_data;
  logic         ct_valid;
  logic         ct_ready;

  modport master (
    output pt_data, pt_valid, ct_ready,
    input  pt_ready, ct_data, ct_valid
  );

  modport slave (
    input  pt_data, pt_valid, ct_ready,
    output pt_ready, ct_data, ct_valid
  );
endinterface

// File: rtl/trivium_ks_xor.sv
// Trivium keystream consumer: holds the core in reset until started, drops
// the warm-up bits, packs the serial keystream LSB first into W-bit words,
// buffers them in a DEPTH-word FIFO (the core cannot be stalled) and XORs
// them with plaintext words to produce ciphertext words.
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-low reset
//   start        one-cycle pulse, honoured only in IDLE
//   abort        back to IDLE from any state, highest priority
//   s            keystream bit from the core, sampled every edge outside IDLE
//   ks_rst       active-high reset to the core, high while IDLE
//   busy         state != IDLE
//   ovf          sticky: a keystream word was dropped on a full FIFO
//   bus          plaintext/ciphertext valid/ready handshakes
//
// state     | meaning
// ST_IDLE   | core held in reset, s ignored, waiting for start
// ST_WARMUP | core running, sampled bits discarded
// ST_RUN    | sampled bits packed into words, plaintext accepted
module trivium_ks_xor #(
  parameter int W      = 8,
  parameter int DEPTH  = 4,
  parameter int WARMUP = 1152
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              s,
  output logic              ks_rst,
  output logic              busy,
  output logic              ovf,
  trivium_ks_xor_if.slave   bus
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PCW = (W > 1) ? $clog2(W) : 1;
  localparam int WCW = $clog2(WARMUP + 2);

  localparam logic [PCW-1:0] PACK_LAST = PCW'(W - 1);
  localparam logic [WCW-1:0] WARM_LOAD = (WARMUP > 0) ? WCW'(WARMUP - 1) : '0;
  localparam logic [AW:0]    FULL_CNT  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [WCW-1:0] warm_cnt;
  logic [PCW-1:0] pack_cnt;
  logic [W-1:0]   pack_sr;
  logic [W-1:0]   word_nxt;
  logic [W-1:0]   mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           fifo_full, fifo_empty;
  logic           push, pop, push_ok;

  assign fifo_full    = (count == FULL_CNT);
  assign fifo_empty   = (count == '0);
  assign ks_rst       = (state == ST_IDLE);
  assign busy         = (state != ST_IDLE);
  assign bus.pt_ready = (state == ST_RUN) && !fifo_empty && (!bus.ct_valid || bus.ct_ready);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
      ST_WARMUP: if (warm_cnt == '0) state_nxt = ST_RUN;
      ST_RUN:    ;
      default:   state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  // The word completing on this edge includes the bit being sampled now,
  // so it is assembled combinationally and pushed on the same edge.
  always_comb begin
    word_nxt           = pack_sr;
    word_nxt[pack_cnt] = s;
    push               = (state == ST_RUN) && (pack_cnt == PACK_LAST);
    pop                = bus.pt_valid && bus.pt_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    push_ok            = push && (!fifo_full || pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (push_ok && !abort) mem[wr_ptr] <= word_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warm_cnt     <= '0;
      pack_cnt     <= '0;
      pack_sr      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      ovf          <= 1'b0;
      bus.ct_valid <= 1'b0;
      bus.ct_data  <= '0;
    end else if (abort) begin
      // ovf deliberately survives an abort so software can still see it.
      warm_cnt     <= '0;
      pack_cnt     <= '0;
      pack_sr      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      bus.ct_valid <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        warm_cnt     <= WARM_LOAD;
        pack_cnt     <= '0;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        count        <= '0;
        ovf          <= 1'b0;
        bus.ct_valid <= 1'b0;
      end
    end else begin
      if (state == ST_WARMUP) begin
        if (warm_cnt != '0) warm_cnt <= warm_cnt - WCW'(1);
      end else begin
        pack_sr  <= word_nxt;
        pack_cnt <= push ? '0 : pack_cnt + PCW'(1);
      end

      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (push && fifo_full && !pop) ovf <= 1'b1;
      if (pop) rd_ptr <= rd_ptr + AW'(1);

      case ({push_ok, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: ;
      endcase

      if (pop) begin
        bus.ct_data  <= bus.pt_data ^ mem[rd_ptr];
        bus.ct_valid <= 1'b1;
      end else if (bus.ct_ready) begin
        bus.ct_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trivium_ks_xor.sv
// Self-checking bench for trivium_ks_xor (W=8, DEPTH=4, WARMUP=4).
// Directed scenarios plus a randomized run against a sample-count based
// reference model of the keystream packer, FIFO and output register.
module tb_trivium_ks_xor;
  localparam int W      = 8;
  localparam int DEPTH  = 4;
  localparam int WARMUP = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic s = 1'b0;
  logic ks_rst, busy, ovf;

  int n_checks = 0;
  int n_fail   = 0;

  trivium_ks_xor_if #(.W(W)) bus ();

  trivium_ks_xor #(.W(W), .DEPTH(DEPTH), .WARMUP(WARMUP)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .s      (s),
    .ks_rst (ks_rst),
    .busy   (busy),
    .ovf    (ovf),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model: m_n counts samples since start; RUN once m_n >= WARMUP.
  bit           m_active = 1'b0;
  int           m_n      = 0;
  logic [W-1:0] m_word   = '0;
  logic [W-1:0] m_q[$];
  bit           m_ctv    = 1'b0;
  bit           m_ovf    = 1'b0;
  logic [W-1:0] m_ctd    = '0;

  function automatic bit exp_ready();
    return m_active && (m_n >= WARMUP) && (m_q.size() > 0) && (!m_ctv || bus.ct_ready);
  endfunction

  always @(posedge clk or negedge rst) begin
    bit           mpop;
    int           k;
    logic [W-1:0] head;
    if (!rst) begin
      m_active = 0; m_n = 0; m_q.delete(); m_ctv = 0; m_ctd = '0; m_ovf = 0;
    end else if (abort) begin
      m_active = 0; m_n = 0; m_q.delete(); m_ctv = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_n = 0; m_q.delete(); m_ctv = 0; m_ovf = 0;
      end
    end else begin
      mpop = bus.pt_valid && exp_ready();
      if (mpop) begin
        head  = m_q.pop_front();
        m_ctd = bus.pt_data ^ head;
        m_ctv = 1;
      end else if (bus.ct_ready) begin
        m_ctv = 0;
      end
      if (m_n >= WARMUP) begin
        k         = (m_n - WARMUP) % W;
        m_word[k] = s;
        if (k == W - 1) begin
          if (m_q.size() == DEPTH) m_ovf = 1;
          else m_q.push_back(m_word);
        end
      end
      m_n++;
    end
  end

  task automatic do_abort();
    abort = 1'b1; bus.pt_valid = 1'b0;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ks_rst, busy, ovf, bus.ct_valid, bus.pt_ready} !== 5'b10000 || bus.ct_data !== '0)
      begin n_fail++; $display("FAIL reset_state: got ks_rst/busy/ovf/ctv/ptr=%b%b%b%b%b ct_data=%h want 10000 00",
        ks_rst, busy, ovf, bus.ct_valid, bus.pt_ready, bus.ct_data); end
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s = 1'($urandom); bus.pt_valid = 1'($urandom); bus.ct_ready = 1'($urandom);
      #1;
      n_checks++;
      if ({ks_rst, busy, bus.pt_ready, bus.ct_valid} !== 4'b1000)
        begin n_fail++; $display("FAIL idle_outputs: got ks_rst/busy/ptr/ctv=%b%b%b%b want 1000",
          ks_rst, busy, bus.pt_ready, bus.ct_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_warmup_pack();
    int bits[12] = '{1, 1, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0};
    start = 1'b1; bus.pt_data = 8'hFF; bus.pt_valid = 1'b1; bus.ct_ready = 1'b1; s = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({busy, ks_rst} !== 2'b10)
      begin n_fail++; $display("FAIL start_release: got busy/ks_rst=%b%b want 10", busy, ks_rst); end
    for (int i = 0; i < 12; i++) begin
      s = 1'(bits[i]);
      #1;
      n_checks++;
      if (bus.pt_ready !== 1'b0)
        begin n_fail++; $display("FAIL pack_ready_early: bit %0d got pt_ready=%b want 0", i, bus.pt_ready); end
      @(negedge clk);
    end
    s = 1'b0;
    #1;
    n_checks++;
    if ({bus.pt_ready, bus.ct_valid} !== 2'b10)
      begin n_fail++; $display("FAIL pack_ready_rise: got ptr/ctv=%b%b want 10", bus.pt_ready, bus.ct_valid); end
    @(negedge clk);
    n_checks++;
    if (bus.ct_valid !== 1'b1 || bus.ct_data !== 8'hF2)
      begin n_fail++; $display("FAIL pack_first_ct: got ctv=%b ct_data=%h want 1 f2", bus.ct_valid, bus.ct_data); end
    do_abort();
  endtask

  task automatic test_back_pressure();
    logic [W-1:0] held;
    start = 1'b1; bus.pt_valid = 1'b0; bus.ct_ready = 1'b0; s = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
    repeat (WARMUP + 2 * W) begin s = 1'($urandom); @(negedge clk); end
    bus.pt_valid = 1'b1; bus.pt_data = W'($urandom); s = 1'($urandom);
    #1;
    n_checks++;
    if (bus.pt_ready !== 1'b1)
      begin n_fail++; $display("FAIL bp_ready_first: got %b want 1", bus.pt_ready); end
    @(negedge clk);
    n_checks++;
    if (bus.ct_valid !== 1'b1 || bus.ct_data !== m_ctd)
      begin n_fail++; $display("FAIL bp_first_ct: got ctv=%b ct_data=%h want 1 %h", bus.ct_valid, bus.ct_data, m_ctd); end
    held = m_ctd;
    for (int i = 0; i < 3; i++) begin
      bus.pt_data = W'($urandom); s = 1'($urandom);
      #1;
      n_checks++;
      if (bus.pt_ready !== 1'b0)
        begin n_fail++; $display("FAIL bp_ready_stall: cycle %0d got pt_ready=%b want 0", i, bus.pt_ready); end
      @(negedge clk);
      n_checks++;
      if (bus.ct_valid !== 1'b1 || bus.ct_data !== held)
        begin n_fail++; $display("FAIL bp_hold: cycle %0d got ctv=%b ct_data=%h want 1 %h", i, bus.ct_valid, bus.ct_data, held); end
    end
    bus.ct_ready = 1'b1; bus.pt_data = W'($urandom); s = 1'($urandom);
    #1;
    n_checks++;
    if (bus.pt_ready !== 1'b1)
      begin n_fail++; $display("FAIL bp_ready_release: got %b want 1", bus.pt_ready); end
    @(negedge clk);
    n_checks++;
    if (bus.ct_valid !== 1'b1 || bus.ct_data !== m_ctd)
      begin n_fail++; $display("FAIL bp_second_ct: got ctv=%b ct_data=%h want 1 %h", bus.ct_valid, bus.ct_data, m_ctd); end
    bus.pt_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.ct_valid !== 1'b0)
      begin n_fail++; $display("FAIL bp_drain: got ctv=%b want 0", bus.ct_valid); end
    do_abort();
  endtask

  // Starts a run with pt_valid low and drives WARMUP+40 random bits,
  // recording the five complete words; optionally pops on the last edge.
  task automatic fill_fifo(output logic [W-1:0] w[5], input bit pop_last, output logic [W-1:0] pd);
    int k;
    pd = W'($urandom);
    start = 1'b1; bus.pt_valid = 1'b0; bus.ct_ready = 1'b1; s = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
    for (int e = 1; e <= WARMUP + 5 * W; e++) begin
      s = 1'($urandom);
      if (e > WARMUP) begin k = e - WARMUP - 1; w[k / W][k % W] = s; end
      if (e == WARMUP + 5 * W && pop_last) begin bus.pt_valid = 1'b1; bus.pt_data = pd; end
      #1;
      if (e == WARMUP + 5 * W) begin
        n_checks++;
        if (ovf !== 1'b0)
          begin n_fail++; $display("FAIL fill_ovf_early: got ovf=%b want 0", ovf); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] w[5];
    logic [W-1:0] pd;
    fill_fifo(w, 1'b0, pd);
    n_checks++;
    if (ovf !== 1'b1)
      begin n_fail++; $display("FAIL ovf_set: got ovf=%b want 1", ovf); end
    for (int i = 0; i < DEPTH; i++) begin
      pd = W'($urandom); bus.pt_data = pd; bus.pt_valid = 1'b1; s = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if (bus.ct_valid !== 1'b1 || bus.ct_data !== (pd ^ w[i]))
        begin n_fail++; $display("FAIL ovf_order: word %0d got ctv=%b ct_data=%h want 1 %h", i, bus.ct_valid, bus.ct_data, pd ^ w[i]); end
    end
    bus.pt_valid = 1'b0;
    n_checks++;
    if (ovf !== 1'b1)
      begin n_fail++; $display("FAIL ovf_sticky: got ovf=%b want 1", ovf); end
  endtask

  task automatic test_reset_mid();
    repeat (3) begin s = 1'($urandom); @(negedge clk); end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({ks_rst, busy, ovf, bus.ct_valid} !== 4'b1000 || bus.ct_data !== '0)
      begin n_fail++; $display("FAIL reset_mid: got ks_rst/busy/ovf/ctv=%b%b%b%b ct_data=%h want 1000 00",
        ks_rst, busy, ovf, bus.ct_valid, bus.ct_data); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s = 1'($urandom); bus.pt_valid = 1'($urandom);
      #1;
      n_checks++;
      if (bus.pt_ready !== 1'b0 || ks_rst !== 1'b1)
        begin n_fail++; $display("FAIL reset_idle_ready: got ptr=%b ks_rst=%b want 0 1", bus.pt_ready, ks_rst); end
      @(negedge clk);
    end
    bus.pt_valid = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [W-1:0] w[5];
    logic [W-1:0] pd;
    fill_fifo(w, 1'b1, pd);
    n_checks++;
    if (ovf !== 1'b0 || bus.ct_valid !== 1'b1 || bus.ct_data !== (pd ^ w[0]))
      begin n_fail++; $display("FAIL fpp_edge: got ovf=%b ctv=%b ct_data=%h want 0 1 %h", ovf, bus.ct_valid, bus.ct_data, pd ^ w[0]); end
    for (int i = 1; i <= DEPTH; i++) begin
      pd = W'($urandom); bus.pt_data = pd; s = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if (bus.ct_valid !== 1'b1 || bus.ct_data !== (pd ^ w[i]))
        begin n_fail++; $display("FAIL fpp_order: word %0d got ctv=%b ct_data=%h want 1 %h", i, bus.ct_valid, bus.ct_data, pd ^ w[i]); end
    end
    #1;
    n_checks++;
    if (bus.pt_ready !== 1'b0 || ovf !== 1'b0)
      begin n_fail++; $display("FAIL fpp_empty: got ptr=%b ovf=%b want 0 0", bus.pt_ready, ovf); end
    do_abort();
  endtask

  task automatic test_abort();
    logic [W-1:0] w0;
    start = 1'b1; bus.pt_valid = 1'b0; bus.ct_ready = 1'b0; s = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
    repeat (WARMUP + 3 * W) begin s = 1'($urandom); @(negedge clk); end
    bus.pt_valid = 1'b1; bus.pt_data = W'($urandom); s = 1'($urandom);
    @(negedge clk);
    bus.pt_valid = 1'b0; s = 1'($urandom);
    @(negedge clk);
    n_checks++;
    if (bus.ct_valid !== 1'b1 || busy !== 1'b1)
      begin n_fail++; $display("FAIL abort_pre: got ctv=%b busy=%b want 1 1", bus.ct_valid, busy); end
    abort = 1'b1; s = 1'b1;
    @(negedge clk);
    abort = 1'b0; bus.pt_valid = 1'b1;
    #1;
    n_checks++;
    if ({busy, ks_rst, bus.ct_valid, bus.pt_ready} !== 4'b0100)
      begin n_fail++; $display("FAIL abort_idle: got busy/ks_rst/ctv/ptr=%b%b%b%b want 0100",
        busy, ks_rst, bus.ct_valid, bus.pt_ready); end
    bus.pt_valid = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int e = 1; e <= WARMUP + W; e++) begin
      s = 1'($urandom);
      if (e > WARMUP) w0[e - WARMUP - 1] = s;
      @(negedge clk);
    end
    bus.pt_valid = 1'b1; bus.pt_data = '0; bus.ct_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.ct_valid !== 1'b1 || bus.ct_data !== w0)
      begin n_fail++; $display("FAIL abort_restart_word: got ctv=%b ct_data=%h want 1 %h", bus.ct_valid, bus.ct_data, w0); end
    do_abort();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      s            = 1'($urandom);
      start        = ($urandom_range(7) == 0);
      abort        = ($urandom_range(99) == 0);
      bus.pt_valid = ($urandom_range(9) < 3);
      bus.ct_ready = ($urandom_range(9) < 6);
      bus.pt_data  = W'($urandom);
      #1;
      n_checks++;
      if (bus.pt_ready !== exp_ready() || bus.ct_valid !== m_ctv || ovf !== m_ovf ||
          busy !== m_active || ks_rst !== !m_active || (m_ctv && bus.ct_data !== m_ctd))
        begin n_fail++; $display("FAIL random_cycle %0d: got ptr=%b ctv=%b ovf=%b busy=%b ct=%h want %b %b %b %b %h",
          i, bus.pt_ready, bus.ct_valid, ovf, busy, bus.ct_data, exp_ready(), m_ctv, m_ovf, m_active, m_ctd); end
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0; bus.pt_valid = 1'b0;
  endtask

  initial begin
    bus.pt_data = '0; bus.pt_valid = 1'b0; bus.ct_ready = 1'b0;
    test_reset();
    test_warmup_pack();
    test_back_pressure();
    test_overflow();
    test_reset_mid();
    test_full_push_pop();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
